// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (tdm_demux receiver, tdm_mux transmitter).
// Holds the default frame geometry, the FSM state encoding and a clog2 helper
// used to size the slot counter.
package tdm_pkg;

  localparam int unsigned CHANNELS_DEF = 4;
  localparam int unsigned WIDTH_DEF    = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // Bits needed to hold 0..n-1; never returns less than 1.
  function automatic int unsigned tdm_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(n)) w = unsigned'(i + 1);
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM receiver.
// Ports:
//   clk, reset    clock, async active-high reset (counter -> 0)
//   inc_i         advance one slot, wrapping explicitly from CHANNELS-1 to 0
//   load1_i       force the counter to 1 (slot 0 was just taken)
//   clr_i         force the counter to 0 (highest priority)
//   slot_o        current slot index
//   last_c        combinational flag: slot_o is CHANNELS-1
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned SW       = tdm_clog2(CHANNELS_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          last_c
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  // Next slot: clear > load-to-1 > increment; wrap is compared, not overflow.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SW'(1);
    end else if (inc_i) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_o = slot_q;
  assign last_c = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: deserializes a slot-rotating word stream,
// framed by a sync strobe on slot 0, into per-channel output registers.
// Ports:
//   clk, reset    clock, async active-high reset
//   valid_in      data_in carries a slot word this cycle
//   sync_in       (with valid_in) the word is slot 0
//   data_in       slot word
//   ch_out        channel k at [k*WIDTH +: WIDTH]
//   frame_valid   one-cycle pulse: ch_out holds a freshly completed frame
//   locked        high while frame alignment is held
//   sync_err      one-cycle pulse on early or missing sync
// Build option TDM_DEMUX_DOUBLE_BUFFER_EN: collect words in shadow registers
// and update ch_out atomically at frame completion. Without it each word goes
// straight to its ch_out slot, so an aborted frame leaves a torn ch_out.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      sync_in,
  input  logic [WIDTH-1:0]          data_in,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int unsigned SW = tdm_clog2(CHANNELS);
  localparam int unsigned CW = CHANNELS * WIDTH;

  tdm_state_e           state_q;
  logic [CW-1:0]        ch_out_q;
  logic                 frame_valid_q;
  logic                 sync_err_q;

  logic [SW-1:0]        slot;
  logic                 last_c;
  logic                 slot_nz_c;
  logic                 is_locked_c;
  logic                 start_c;
  logic                 data_c;
  logic                 early_c;
  logic                 miss_c;
  logic                 done_c;
  logic                 store_c;
  logic [SW-1:0]        wr_slot_c;

  // Word classification for this cycle.
  always_comb begin
    slot_nz_c   = (slot != '0);
    is_locked_c = (state_q == LOCKED);
    start_c     = valid_in & sync_in;
    data_c      = valid_in & ~sync_in & is_locked_c & slot_nz_c;
    early_c     = valid_in & sync_in & is_locked_c & slot_nz_c;
    miss_c      = valid_in & ~sync_in & is_locked_c & ~slot_nz_c;
    done_c      = data_c & last_c;
    store_c     = start_c | data_c;
    wr_slot_c   = start_c ? '0 : slot;
  end

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (data_c),
    .load1_i (start_c),
    .clr_i   (miss_c),
    .slot_o  (slot),
    .last_c  (last_c)
  );

`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
  logic [CW-1:0] shadow_q;
  logic [CW-1:0] frame_d;

  // Completed frame = shadows plus the last-slot word arriving now.
  always_comb begin
    frame_d = shadow_q;
    frame_d[32'(slot)*WIDTH +: WIDTH] = data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (store_c) begin
      shadow_q[32'(wr_slot_c)*WIDTH +: WIDTH] <= data_in;
    end
  end
`endif

  // FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= done_c;
      sync_err_q    <= early_c | miss_c;
      if (miss_c) begin
        state_q <= HUNT;
      end else if (start_c) begin
        state_q <= LOCKED;
      end
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
      if (done_c) ch_out_q <= frame_d;
`else
      if (store_c) ch_out_q[32'(wr_slot_c)*WIDTH +: WIDTH] <= data_in;
`endif
    end
  end

  assign ch_out      = ch_out_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;

  logic            clk;
  logic            reset;
  logic            valid_in;
  logic            sync_in;
  logic [W-1:0]    data_in;
  logic [CH*W-1:0] ch_out;
  logic            frame_valid;
  logic            locked;
  logic            sync_err;

  int checks;
  int errors;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .sync_in     (sync_in),
    .data_in     (data_in),
    .ch_out      (ch_out),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        fv;
    logic        lk;
    logic        er;
    logic        cc;
    logic [31:0] ch;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic fv,
                              logic lk, logic er, logic cc, logic [31:0] ch);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.fv = fv; r.lk = lk; r.er = er; r.cc = cc; r.ch = ch;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of input; return just after the sampling edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    valid_in = v;
    sync_in  = s;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] torn_exp;
  int          fv_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    data_in  = '0;
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
    torn_exp = 32'h04030201;
`else
    torn_exp = 32'h04032255;
`endif

    // v, s, data, fv, locked, err, check_ch, ch
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h22, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h33, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h44, 1, 1, 0, 1, 32'h44332211));
    vecs.push_back(mk(1, 0, 8'h99, 0, 0, 1, 1, 32'h44332211));  // missing sync
    vecs.push_back(mk(1, 0, 8'hAA, 0, 0, 0, 1, 32'h44332211));  // hunt drops
    vecs.push_back(mk(1, 0, 8'hBB, 0, 0, 0, 1, 32'h44332211));
    vecs.push_back(mk(1, 1, 8'h01, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 8'hEE, 0, 1, 0, 0, 32'h0));         // idle holds slot
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h03, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h04, 1, 1, 0, 1, 32'h04030201));
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h22, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 8'h55, 0, 1, 1, 1, torn_exp));      // early sync
    vecs.push_back(mk(1, 0, 8'h66, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h77, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 8'h88, 1, 1, 0, 1, 32'h88776655));
    vecs.push_back(mk(0, 1, 8'hCC, 0, 1, 0, 1, 32'h88776655));  // sync without valid

    // Reset state
    #12;
    chk("reset_ch", ch_out, 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(sync_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d);
      chk($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vecs[i].fv));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("vec%0d_err", i), 32'(sync_err), 32'(vecs[i].er));
      if (vecs[i].cc) chk($sformatf("vec%0d_ch", i), ch_out, vecs[i].ch);
    end

    // Gapped frame: three idle cycles between words
    fv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k == 0), 8'(k + 1));
      if (frame_valid) fv_cnt++;
      if (sync_err) chk("gap_err", 32'(sync_err), 32'h0);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 8'hFF);
        if (frame_valid) fv_cnt++;
      end
    end
    chk("gap_fv_count", 32'(fv_cnt), 32'd1);
    chk("gap_ch", ch_out, 32'h04030201);
    chk("gap_locked", 32'(locked), 32'h1);

    // Back-to-back frames: frame_valid every CHANNELS cycles
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k % 4 == 0), (k < 4) ? 8'(8'hA1 + k) : 8'(8'hB1 + k - 4));
      chk($sformatf("b2b%0d_fv", k), 32'(frame_valid), 32'((k == 3) || (k == 7)));
      if (k == 3) chk("b2b_chA", ch_out, 32'hA4A3A2A1);
      if (k == 7) chk("b2b_chB", ch_out, 32'hB4B3B2B1);
    end

    // Async reset mid-frame
    step(1'b1, 1'b1, 8'h21);
    step(1'b1, 1'b0, 8'h22);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ch", ch_out, 32'h0);
    chk("arst_locked", 32'(locked), 32'h0);
    chk("arst_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k == 0), 8'(8'h31 + k));
      chk($sformatf("post_rst%0d_fv", k), 32'(frame_valid), 32'(k == 3));
    end
    chk("post_rst_ch", ch_out, 32'h34333231);
    chk("post_rst_locked", 32'(locked), 32'h1);
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_fv_drop", 32'(frame_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives a single WIDTH-bit word stream in which consecutive valid words belong to channels 0..CHANNELS-1 in rotation, with frame alignment marked by a sync strobe. It deserializes each frame into per-channel output registers. It is the receive end of the team's select-counter-driven MUX link between LittleComputer datapath blocks. A frame-valid pulse is raised when a complete frame has been captured.

## Interface
- CHANNELS, 4, number of slots per frame (2..16)
- WIDTH, 8, bits per slot word
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  data_in holds a slot word this cycle
- sync_in  input  1  qualified by valid_in; marks the word as slot 0
- data_in  input  WIDTH  slot word
- ch_out  output  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse; ch_out just updated with a complete frame
- locked  output  1  high while in LOCKED
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT, LOCKED. Reset enters HUNT, clears slot counter, shadow registers, ch_out, frame_valid, locked and sync_err to 0.
- Cycles with valid_in=0 change nothing; the slot counter holds.
- HUNT: valid_in=1 with sync_in=0 is dropped. valid_in=1 with sync_in=1 stores data_in in shadow slot 0, sets slot to 1, and enters LOCKED.
- LOCKED, valid_in=1:
  - sync_in=0 and slot≠0: store the word in shadow[slot], then increment slot.
  - Storing slot CHANNELS-1 copies all shadows to ch_out, pulses frame_valid, and wraps slot to 0.
  - sync_in=1 and slot=0: normal frame start; store the word, set slot to 1.
  - sync_in=1 and slot≠0 (early sync): pulse sync_err, discard the partial frame (ch_out unchanged), store the word as slot 0, set slot to 1, stay LOCKED.
  - sync_in=0 and slot=0 (missing sync): pulse sync_err, drop the word, go to HUNT.
- Slot counter width is clog2(CHANNELS). It never exceeds CHANNELS-1 and wraps explicitly to 0, not by overflow.
- Async reset mid-frame: partial frame lost, ch_out cleared to 0, no frame_valid.

## Timing
- All outputs are registered.
- frame_valid and the ch_out update appear on the same edge, one cycle after the edge that samples the last-slot word.
- sync_err is asserted in the cycle after the offending word is sampled.
- locked rises the cycle after the first sync word is sampled in HUNT. It falls the cycle after a missing-sync word is sampled.
- Throughput: one word per cycle sustained; back-to-back frames yield frame_valid every CHANNELS cycles.
- frame_valid and sync_err are never high in the same cycle.

## Configuration
- TDM_DEMUX_DOUBLE_BUFFER_EN defined: behaviour as described above.
  - Shadow registers are used; ch_out changes only atomically at frame completion.
  - A discarded partial frame never reaches ch_out.
- Undefined: no shadow registers; each accepted word is written directly to its ch_out slot one cycle after sampling.
  - frame_valid still pulses on completion of the last slot.
  - On early sync or missing sync, already-written slots keep their new values. A torn frame is visible.

## Structure
- Shared header/package tdm_pkg holds:
  - state encoding constants (HUNT=0, LOCKED=1)
  - a clog2 function for slot-counter width
  - CHANNELS/WIDTH defaults, reused by the future tdm_mux transmitter
- One natural sub-module: tdm_slot_counter (increment-on-enable, load-to-1, clear, explicit wrap at CHANNELS-1, last-slot flag).

## Test plan
- Reset then clean frame, CHANNELS=4, WIDTH=8: valid words 0x11(sync), 0x22, 0x33, 0x44 -> frame_valid one cycle after 0x44; ch_out=0x44332211; locked=1.
- HUNT filtering: words 0xAA, 0xBB without sync, then a clean frame 0x01(sync), 0x02, 0x03, 0x04 -> no frame_valid before the clean frame; ch_out=0x04030201.
- Gapped input: the same clean frame with valid_in=0 for 3 cycles between every word -> identical ch_out; frame_valid exactly once.
- Early sync: 0x11(sync), 0x22, then 0x55(sync), 0x66, 0x77, 0x88 -> sync_err once on the 0x55 word; ch_out=0x88776655 (with the macro, never partially updated); no frame_valid before the 0x88 word.
- Missing sync: after a complete frame, next word 0x99 with sync_in=0 -> sync_err pulse; locked=0 next cycle; ch_out unchanged.
- Async reset asserted mid-frame after 2 words -> ch_out=0, locked=0 immediately. A subsequent clean frame captures correctly.
